// File: rtl/ads1672_sample_buffer.sv
// ADS1672 sample buffer: FWFT FIFO of formatted 32-bit sample words with drop accounting.
// Define ADS_SAMPLE_SEQ_TAG_EN to tag each word with an 8-bit sequence number instead of sign extension.
module ads1672_sample_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [23:0]              sample_in,
  input  logic                     sample_valid,
  input  logic                     clear,
  output logic [31:0]              m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [15:0]              dropped_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   word;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;

  assign full = (level == LW'(DEPTH));
  assign pop  = m_valid & m_ready & ~clear;
  // A full FIFO still takes a sample when the head word leaves in the same cycle.
  assign push = sample_valid & ~clear & (~full | pop);
  assign drop = sample_valid & ~clear & full & ~pop;

`ifdef ADS_SAMPLE_SEQ_TAG_EN
  logic [7:0] seq;

  assign word = {seq, sample_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq <= 8'h00;
    end else if (clear) begin
      seq <= 8'h00;
    end else if (sample_valid) begin
      seq <= seq + 8'h01;
    end
  end
`else
  assign word = {{8{sample_in[23]}}, sample_in};
`endif

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      overflow    <= 1'b0;
      dropped_cnt <= 16'h0000;
    end else if (clear) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      overflow    <= 1'b0;
      dropped_cnt <= 16'h0000;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level + LW'(push) - LW'(pop);
      if (drop) begin
        overflow <= 1'b1;
        if (dropped_cnt != 16'hFFFF) begin
          dropped_cnt <= dropped_cnt + 16'h0001;
        end
      end
    end
  end

  // Gating on occupancy keeps the unreset storage off the output when empty or in reset.
  assign m_valid = (level != '0);
  assign m_data  = m_valid ? mem[rd_ptr] : 32'h0;

endmodule

// File: tb/tb_ads1672_sample_buffer.sv
// Bench for ads1672_sample_buffer: table vectors, directed corner sequences and a random run against a queue model.
module tb_ads1672_sample_buffer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [23:0] sample_in;
  logic        sample_valid;
  logic        clear;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] dropped_cnt;

  ads1672_sample_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .sample_in(sample_in), .sample_valid(sample_valid),
    .clear(clear), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .level(level), .overflow(overflow), .dropped_cnt(dropped_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: queue of formatted words plus sequence/overflow/drop state.
  logic [31:0] mq[$];
  int          mseq;
  bit          mov;
  int          mdr;

  function automatic logic [31:0] fmt(input logic [23:0] s, input int sq);
`ifdef ADS_SAMPLE_SEQ_TAG_EN
    logic [7:0] t;
    t = 8'(sq % 256);
    return {t, s};
`else
    return {{8{s[23]}}, s};
`endif
  endfunction

  function automatic void model_reset();
    mq.delete();
    mseq = 0;
    mov  = 1'b0;
    mdr  = 0;
  endfunction

  function automatic void model_step(input bit sv, input logic [23:0] s, input bit clr, input bit rdy);
    bit popped;
    if (clr) begin
      model_reset();
    end else begin
      popped = (mq.size() != 0) && rdy;
      if (sv && !(mq.size() < DEPTH || popped)) begin
        mov = 1'b1;
        if (mdr < 65535) mdr++;
      end
      if (popped) void'(mq.pop_front());
      if (sv && mq.size() < DEPTH) mq.push_back(fmt(s, mseq));
      if (sv) mseq = (mseq + 1) % 256;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("level", 32'(level), 32'(mq.size()));
    chk("m_valid", 32'(m_valid), 32'(mq.size() != 0));
    chk("m_data", m_data, (mq.size() != 0) ? mq[0] : 32'h0);
    chk("overflow", 32'(overflow), 32'(mov));
    chk("dropped_cnt", 32'(dropped_cnt), 32'(mdr));
  endtask

  // Inputs are applied at the falling edge, the model advances at the rising edge,
  // and outputs are compared at the following falling edge.
  task automatic step(input bit sv, input logic [23:0] s, input bit clr, input bit rdy);
    sample_valid = sv;
    sample_in    = s;
    clear        = clr;
    m_ready      = rdy;
    @(posedge clk);
    model_step(sv, s, clr, rdy);
    @(negedge clk);
    check_model();
  endtask

  typedef struct {
    bit          sv;
    logic [23:0] s;
    bit          clr;
    bit          rdy;
    bit          ev;
    logic [31:0] ed;
    int          el;
  } vec_t;

  vec_t vt[6];

  initial begin
    vt[0] = '{1'b1, 24'h800001, 1'b0, 1'b1, 1'b1, 32'h0, 1};
    vt[1] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 32'h0, 0};
    vt[2] = '{1'b1, 24'h000123, 1'b0, 1'b0, 1'b1, 32'h0, 1};
    vt[3] = '{1'b1, 24'h7FFFFF, 1'b0, 1'b0, 1'b1, 32'h0, 2};
    vt[4] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b1, 32'h0, 1};
    vt[5] = '{1'b0, 24'h000000, 1'b0, 1'b1, 1'b0, 32'h0, 0};
`ifdef ADS_SAMPLE_SEQ_TAG_EN
    vt[0].ed = 32'h00800001; vt[2].ed = 32'h01000123;
    vt[3].ed = 32'h01000123; vt[4].ed = 32'h027FFFFF;
`else
    vt[0].ed = 32'hFF800001; vt[2].ed = 32'h00000123;
    vt[3].ed = 32'h00000123; vt[4].ed = 32'h007FFFFF;
`endif

    rst_n = 1'b0; sample_valid = 1'b0; sample_in = '0; clear = 1'b0; m_ready = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_model();
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      step(vt[i].sv, vt[i].s, vt[i].clr, vt[i].rdy);
      chk("vec_level", 32'(level), 32'(vt[i].el));
      chk("vec_valid", 32'(m_valid), 32'(vt[i].ev));
      chk("vec_data", m_data, vt[i].ed);
    end

    // Overflow: 20 pushes into a stalled FIFO, fresh sequence after a clear.
    step(1'b0, 24'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 24'(i), 1'b0, 1'b0);
    chk("ovf_level", 32'(level), 32'd16);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_dropped", 32'(dropped_cnt), 32'd4);
    for (int i = 0; i < 16; i++) begin
      chk("drain_word", m_data, fmt(24'(i), i));
      step(1'b0, 24'h0, 1'b0, 1'b1);
    end
    step(1'b1, 24'h000100, 1'b0, 1'b0);
    chk("after_drop_word", m_data, fmt(24'h000100, 20));

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < 15; i++) step(1'b1, 24'(32'h200 + i), 1'b0, 1'b0);
    chk("refill_level", 32'(level), 32'd16);
    step(1'b1, 24'h000300, 1'b0, 1'b1);
    chk("pushpop_level", 32'(level), 32'd16);
    chk("pushpop_dropped", 32'(dropped_cnt), 32'd4);

    // Clear at level 5 with a sample and a pop request in the same cycle.
    for (int i = 0; i < 11; i++) step(1'b0, 24'h0, 1'b0, 1'b1);
    chk("pre_clear_level", 32'(level), 32'd5);
    step(1'b1, 24'h000555, 1'b1, 1'b1);
    chk("clear_level", 32'(level), 32'd0);
    chk("clear_valid", 32'(m_valid), 32'd0);
    chk("clear_ovf", 32'(overflow), 32'd0);
    chk("clear_dropped", 32'(dropped_cnt), 32'd0);

    // 300 streaming pushes: sequence wraps, order preserved, nothing dropped.
    for (int i = 0; i < 300; i++) step(1'b1, 24'($urandom), 1'b0, 1'b1);
    chk("stream_dropped", 32'(dropped_cnt), 32'd0);
    chk("stream_ovf", 32'(overflow), 32'd0);

    // Random traffic with occasional clears.
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, 24'($urandom), ($urandom % 60) == 0, ($urandom % 3) == 0);

    // Asynchronous reset mid-operation at level 7 with overflow set.
    step(1'b0, 24'h0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b1, 24'(32'h400 + i), 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 24'h0, 1'b0, 1'b1);
    chk("pre_reset_level", 32'(level), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", m_data, 32'h0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_dropped", 32'(dropped_cnt), 32'd0);
    step(1'b0, 24'h0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 24'h00ABCD, 1'b0, 1'b0);
    chk("post_reset_word", m_data, fmt(24'h00ABCD, 0));
    step(1'b0, 24'h0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
